// File: rtl/cache_sdreq_arbiter.sv
// Shares the single SDREQ channel between the CDREQ and SUREQ engines and routes SURSP back by owner.
// Latency: grant one cycle after request valid, responses routed combinationally; backpressure via sdreq_ready, tracker-full and engine rsp_ready.
// Optional CACHE_SDREQ_SNP_PRIO_EN: snoop engine always wins a tie instead of round-robin.
module cache_sdreq_arbiter #(
    parameter int SADDR_WIDTH = 32,
    parameter int BLK_WIDTH   = 512,
    parameter int OP_WIDTH    = 3,
    parameter int OUTST_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   cd_req_valid,
    input  logic [OP_WIDTH-1:0]    cd_req_op,
    input  logic [SADDR_WIDTH-1:0] cd_req_addr,
    input  logic [BLK_WIDTH-1:0]   cd_req_data,
    output logic                   cd_req_ready,

    input  logic                   su_req_valid,
    input  logic [OP_WIDTH-1:0]    su_req_op,
    input  logic [SADDR_WIDTH-1:0] su_req_addr,
    input  logic [BLK_WIDTH-1:0]   su_req_data,
    output logic                   su_req_ready,

    output logic                   sdreq_valid,
    input  logic                   sdreq_ready,
    output logic [OP_WIDTH-1:0]    sdreq_op,
    output logic [SADDR_WIDTH-1:0] sdreq_addr,
    output logic [BLK_WIDTH-1:0]   sdreq_data,

    input  logic                   sursp_valid,
    input  logic [OP_WIDTH-1:0]    sursp_op,
    input  logic [BLK_WIDTH-1:0]   sursp_data,
    output logic                   sursp_ready,

    output logic                   cd_rsp_valid,
    input  logic                   cd_rsp_ready,
    output logic                   su_rsp_valid,
    input  logic                   su_rsp_ready,
    output logic [OP_WIDTH-1:0]    rsp_op,
    output logic [BLK_WIDTH-1:0]   rsp_data,

    output logic                   err_unexp_rsp
);

    localparam int PW = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
    localparam int CW = $clog2(OUTST_DEPTH + 1);
    localparam logic OWN_CD = 1'b0;
    localparam logic OWN_SU = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_CD = 2'd1,
        GNT_SU = 2'd2
    } state_t;

    state_t                 state;
    logic                   last_gnt;
    logic                   tie_su;
    logic                   sel_su;
    logic                   gnt_valid;
    logic                   req_hs;

    logic [OUTST_DEPTH-1:0] trk_mem;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          trk_cnt;
    logic                   trk_full;
    logic                   trk_empty;
    logic                   trk_push;
    logic                   trk_pop;
    logic                   owner;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTST_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign trk_full  = (trk_cnt == CW'(OUTST_DEPTH));
    assign trk_empty = (trk_cnt == '0);
    assign owner     = trk_mem[rd_ptr];

    always_comb begin
`ifdef CACHE_SDREQ_SNP_PRIO_EN
        tie_su = 1'b1;
`else
        tie_su = (last_gnt == OWN_CD);
`endif
    end

    // Request mux: only the granted engine's fields reach SDREQ
    always_comb begin
        sel_su       = (state == GNT_SU);
        gnt_valid    = ((state == GNT_CD) && cd_req_valid) ||
                       ((state == GNT_SU) && su_req_valid);
        sdreq_valid  = gnt_valid && !trk_full;
        sdreq_op     = sel_su ? su_req_op   : cd_req_op;
        sdreq_addr   = sel_su ? su_req_addr : cd_req_addr;
        sdreq_data   = sel_su ? su_req_data : cd_req_data;
        cd_req_ready = (state == GNT_CD) && sdreq_ready && !trk_full;
        su_req_ready = (state == GNT_SU) && sdreq_ready && !trk_full;
        req_hs       = sdreq_valid && sdreq_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= OWN_SU;
        end else begin
            case (state)
                IDLE: begin
                    if (cd_req_valid && su_req_valid) begin
                        state <= tie_su ? GNT_SU : GNT_CD;
                    end else if (cd_req_valid) begin
                        state <= GNT_CD;
                    end else if (su_req_valid) begin
                        state <= GNT_SU;
                    end
                end
                GNT_CD: begin
                    if (req_hs) begin
                        state    <= IDLE;
                        last_gnt <= OWN_CD;
                    end else if (!cd_req_valid) begin
                        state <= IDLE;
                    end
                end
                GNT_SU: begin
                    if (req_hs) begin
                        state    <= IDLE;
                        last_gnt <= OWN_SU;
                    end else if (!su_req_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In-order owner tracker; a response with nothing outstanding is swallowed
    assign trk_push = req_hs;
    assign trk_pop  = sursp_valid && sursp_ready && !trk_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            trk_cnt <= '0;
        end else begin
            if (trk_push) begin
                trk_mem[wr_ptr] <= sel_su;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (trk_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({trk_push, trk_pop})
                2'b10:   trk_cnt <= trk_cnt + 1'b1;
                2'b01:   trk_cnt <= trk_cnt - 1'b1;
                default: trk_cnt <= trk_cnt;
            endcase
        end
    end

    always_comb begin
        cd_rsp_valid = sursp_valid && !trk_empty && (owner == OWN_CD);
        su_rsp_valid = sursp_valid && !trk_empty && (owner == OWN_SU);
        if (trk_empty) begin
            sursp_ready = sursp_valid;
        end else begin
            sursp_ready = (owner == OWN_SU) ? su_rsp_ready : cd_rsp_ready;
        end
        rsp_op   = sursp_op;
        rsp_data = sursp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexp_rsp <= 1'b0;
        end else if (sursp_valid && trk_empty) begin
            err_unexp_rsp <= 1'b1;
        end
    end

endmodule
